// File: rtl/outer_prod_sched.sv
// Source-side outer-product scheduler: captures vectors A and B, then streams
// all N*N products A[i]*B[j] row-major into an async FIFO write port.
`timescale 1ns/1ps

module outer_prod_sched #(
   parameter int N  = 16,
   parameter int DW = 4
) (
   input  logic            clk1,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_matrix_A,
   input  logic [DW-1:0]   in_matrix_B,
   input  logic            fifo_full,
   output logic            fifo_winc,
   output logic [2*DW-1:0] fifo_wdata,
   output logic            busy,
   output logic            done
);

   localparam int LOG2N = $clog2(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]         state;
   logic [LOG2N-1:0]   load_cnt;
   logic [2*LOG2N-1:0] send_cnt;
   logic [DW-1:0]      a_buf [N];
   logic [DW-1:0]      b_buf [N];

   logic [LOG2N-1:0]   row_idx;
   logic [LOG2N-1:0]   col_idx;
   logic [2*DW-1:0]    a_ext;
   logic [2*DW-1:0]    b_ext;

   assign row_idx = send_cnt[2*LOG2N-1:LOG2N];
   assign col_idx = send_cnt[LOG2N-1:0];

   // Zero-extend before multiplying so the product keeps its full 2*DW width.
   assign a_ext = {{DW{1'b0}}, a_buf[row_idx]};
   assign b_ext = {{DW{1'b0}}, b_buf[col_idx]};

   // NOTE: the operand buffers are reset too; they are small register files,
   // and a cleared buffer keeps fifo_wdata deterministic after any abort.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         load_cnt <= '0;
         send_cnt <= '0;
         done     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            a_buf[i] <= '0;
            b_buf[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_buf[0] <= in_matrix_A;
                  b_buf[0] <= in_matrix_B;
                  load_cnt <= LOG2N'(1);
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  a_buf[load_cnt] <= in_matrix_A;
                  b_buf[load_cnt] <= in_matrix_B;
                  load_cnt        <= load_cnt + 1'b1;
                  if (load_cnt == LOG2N'(N-1)) begin
                     state    <= S_SEND;
                     send_cnt <= '0;
                  end
               end
            end
            S_SEND: begin
               // A held write (fifo_full) leaves send_cnt untouched, so the
               // same product is re-presented until it is accepted.
               if (fifo_winc) begin
                  send_cnt <= send_cnt + 1'b1;
                  if (send_cnt == '1) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // NOTE: every output gets a default before the decode so no latch is inferred.
   always_comb begin
      busy       = 1'b0;
      fifo_winc  = 1'b0;
      fifo_wdata = '0;
      if (state == S_LOAD || state == S_SEND)
         busy = 1'b1;
      if (state == S_SEND && !fifo_full)
         fifo_winc = 1'b1;
      if (fifo_winc)
         fifo_wdata = a_ext * b_ext;
   end

endmodule

// File: doc/outer_prod_sched.md
Name: outer_prod_sched

Overview:
- Single-clock scheduler on the source side of the matrix outer-product path.
- Captures N-element vectors A and B, then pushes all N*N products A[i]*B[j] into the downstream asynchronous FIFO write port. Order is row-major: i outer, j inner.
- Paces the stream on the FIFO full flag so that no product is lost or duplicated.
- The consumer clock domain drains the FIFO and drives out_valid/out_matrix.

Parameters:
- N, 16, elements per input vector; must be a power of two; the burst is N*N products.
- DW, 4, bit width of each A/B element; product width is 2*DW.

Ports:
- clk1  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B element pair valid this cycle.
- in_matrix_A  input  DW  element of vector A.
- in_matrix_B  input  DW  element of vector B.
- fifo_full  input  1  downstream FIFO full, already synchronised into the clk1 domain.
- fifo_winc  output  1  FIFO write enable; a write occurs on each rising edge where it is 1.
- fifo_wdata  output  2*DW  product being written.
- busy  output  1  high in LOAD and SEND.
- done  output  1  one-cycle pulse after the final product is written.

Behaviour:
- States: IDLE, LOAD, SEND, FIN. State, counters, A/B buffers and done are registers.
- fifo_winc, fifo_wdata and busy are combinational decodes of registered state and of fifo_full.
- Reset (asynchronous, any time): state = IDLE, load_cnt = 0, send_cnt = 0, done = 0. The A/B buffers are cleared to 0. fifo_winc, fifo_wdata and busy all read 0 while rst_n is low.
- Reset mid-LOAD or mid-SEND aborts the burst. Captured data is discarded and products already written stay in the FIFO; flushing them is the consumer's responsibility.
- IDLE:
  - When in_valid = 1: store A[0] and B[0], set load_cnt = 1, go to LOAD.
  - N = 1 is not supported.
- LOAD:
  - Each cycle with in_valid = 1 stores the pair at index load_cnt and increments load_cnt.
  - Gaps in in_valid are allowed; the block stalls without timeout.
  - On the cycle the element at index N-1 is captured: go to SEND, send_cnt = 0.
- SEND:
  - fifo_winc = !fifo_full.
  - fifo_wdata = A[send_cnt[2*log2N-1:log2N]] * B[send_cnt[log2N-1:0]]. This is an unsigned full-width product, max (2^DW-1)^2, never truncated.
  - fifo_wdata is forced to 0 whenever fifo_winc = 0.
  - On each edge with fifo_winc = 1: send_cnt increments.
  - When send_cnt = N*N-1 is written: go to FIN; send_cnt wraps to 0.
  - fifo_full = 1 holds send_cnt and emits no write. Products are never skipped or repeated.
- FIN:
  - done = 1 for exactly one cycle, then IDLE.
  - busy = 0 and fifo_winc = 0 in FIN.
- in_valid behaviour by state:
  - In SEND and FIN, in_valid is ignored; buffers are not modified.
  - In IDLE, a new burst may start on the cycle immediately after FIN.
- Latency:
  - The first write can occur on the rising edge one cycle after the edge that captured element N-1.
  - With fifo_full held 0: exactly N*N consecutive write cycles, then FIN. Total from first in_valid is N + N*N + 1 cycles.
- fifo_full arriving on the same cycle as the last write blocks that write. The block stays in SEND until the write is accepted.

Test Plan:
- Basic burst, fifo_full = 0, A = 0..15, B = 15..0 → 256 consecutive fifo_winc cycles. Word k = (k>>4)*(15-(k&15)); word 17 = 14, word 255 = 0. done pulses on the cycle after the last write; busy drops in the same cycle.
- Max values, A = B = all 15 → every word = 225 (8'hE1); no truncation.
- Backpressure: assert fifo_full for 5 cycles starting at send index 100, and again during index 255 → no writes while full. Writes resume at index 100 with the same value. Written sequence equals the golden 256 with no gaps or duplicates; done appears only after index 255 is written.
- Gapped load: in_valid toggles 1/0 across 32 cycles delivering 16 pairs → identical output to an ungapped load. in_valid pulses during SEND leave the buffers and output unchanged.
- Reset mid-SEND at send index 60 → fifo_winc = 0, fifo_wdata = 0 and busy = 0 immediately, without waiting for a clock edge. A following fresh 16-pair burst produces the full 256-word sequence starting at index 0.
- Back-to-back: 1000 random bursts, each new in_valid starting the cycle after done, with random fifo_full → every burst matches the golden A[i]*B[j] row-major stream.
